// File: rtl/if_id_fifo_if.sv
// IF/ID pipeline FIFO interface.
// Carries the fetch-to-decode handshake, the fetched instruction entry, the
// flush request and the FIFO status outputs.
interface if_id_fifo_if #(
   parameter int unsigned DEPTH = 4
);

   // Formal-interface observation fields carried alongside each instruction
   typedef struct packed {
      logic        monitor_valid;
      logic [63:0] monitor_order;
      logic [31:0] monitor_inst;
      logic [31:0] monitor_pc_rdata;
      logic [31:0] monitor_pc_wdata;
   } rvfi_t;

   // One fetched instruction as handed from IF to ID
   typedef struct packed {
      logic [31:0] pc;
      logic        branch_pred;
      logic [31:0] predicted_pc;
      rvfi_t       rvfi;
   } if_id_reg_t;

   logic                       enq_valid;
   if_id_reg_t                 enq_data;
   logic                       enq_ready;
   logic                       deq_valid;
   if_id_reg_t                 deq_data;
   logic                       deq_ready;
   logic                       flush;
   logic [$clog2(DEPTH):0]     count;
   logic                       overflow_err;

   // FIFO side
   modport slave (
      input  enq_valid,
      input  enq_data,
      input  deq_ready,
      input  flush,
      output enq_ready,
      output deq_valid,
      output deq_data,
      output count,
      output overflow_err
   );

   // Fetch/decode side
   modport master (
      output enq_valid,
      output enq_data,
      output deq_ready,
      output flush,
      input  enq_ready,
      input  deq_valid,
      input  deq_data,
      input  count,
      input  overflow_err
   );

endinterface

// File: rtl/if_id_fifo.sv
// IF/ID decoupling FIFO.
// Circular buffer of DEPTH fetched entries between fetch and decode. Ready and
// valid derive only from the registered occupancy, so there is no combinational
// path from enqueue to dequeue. Flush empties the FIFO on the next edge; an
// enqueue attempted while full is dropped and latches a sticky error.
module if_id_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   if_id_fifo_if.slave  bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   // NOP (addi x0, x0, 0) presented to decode when no entry is available
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Layout must stay identical to if_id_fifo_if::rvfi_t / if_id_reg_t; the
   // packed structs are assigned to each other bit-for-bit.
   typedef struct packed {
      logic        monitor_valid;
      logic [63:0] monitor_order;
      logic [31:0] monitor_inst;
      logic [31:0] monitor_pc_rdata;
      logic [31:0] monitor_pc_wdata;
   } rvfi_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        branch_pred;
      logic [31:0] predicted_pc;
      rvfi_t       rvfi;
   } entry_t;

   // Storage has no reset: validity is tracked purely by the pointers/count
   entry_t mem [DEPTH];

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;

   logic   enq_ready;
   logic   deq_valid;
   logic   enq_fire;
   logic   deq_fire;
   entry_t enq_entry;
   entry_t head_entry;
   entry_t out_entry;

   // Handshake status from registered occupancy only
   always_comb begin
      enq_ready = (count_q != CNT_W'(DEPTH));
      deq_valid = (count_q != '0);
      enq_fire  = bus.enq_valid & enq_ready & ~bus.flush;
      deq_fire  = deq_valid & bus.deq_ready & ~bus.flush;
   end

   // Next-state for pointers, occupancy and the sticky overflow flag
   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (bus.enq_valid & ~enq_ready & ~bus.flush);

      if (bus.flush) begin
         // Flush wins over any same-cycle enqueue or dequeue
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (enq_fire) begin
            wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
         end
         if (deq_fire) begin
            rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
         end
         unique case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign enq_entry = bus.enq_data;

   // Entry storage write at the write pointer
   always_ff @(posedge clk) begin
      if (enq_fire) begin
         mem[wptr_q] <= enq_entry;
      end
   end

   // Head presentation; an empty FIFO shows a bubble built on the head slot
   always_comb begin
      head_entry = mem[rptr_q];
      out_entry  = head_entry;
      if (!deq_valid) begin
         out_entry.rvfi.monitor_valid = 1'b0;
         out_entry.rvfi.monitor_inst  = NOP_INST;
         out_entry.branch_pred        = 1'b0;
      end
   end

   assign bus.enq_ready    = enq_ready;
   assign bus.deq_valid    = deq_valid;
   assign bus.deq_data     = out_entry;
   assign bus.count        = count_q;
   assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_if_id_fifo.sv
// Bench for if_id_fifo: directed stimulus pushes each entry that should be
// accepted into a scoreboard queue; a negedge monitor pops and compares every
// entry the DUT hands to decode.
module tb_if_id_fifo;

   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   if_id_fifo_if #(.DEPTH(DEPTH)) bus ();

   if_id_fifo #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   function automatic logic [31:0] pred_of(input logic [31:0] pc);
      return pc + 32'd8;
   endfunction

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0093;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_enq(input logic [31:0] pc, input bit accept);
      bus.enq_valid                      = 1'b1;
      bus.enq_data.pc                    = pc;
      bus.enq_data.branch_pred           = pc[2];
      bus.enq_data.predicted_pc          = pred_of(pc);
      bus.enq_data.rvfi.monitor_valid    = 1'b1;
      bus.enq_data.rvfi.monitor_order    = {32'h0, pc};
      bus.enq_data.rvfi.monitor_inst     = inst_of(pc);
      bus.enq_data.rvfi.monitor_pc_rdata = pc;
      bus.enq_data.rvfi.monitor_pc_wdata = pc + 32'd4;
      if (accept) exp_q.push_back(pc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every entry decode consumes must be the next expected one
   always @(negedge clk) begin
      if (!rst && !bus.flush && bus.deq_valid && bus.deq_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL deq_unexpected: got pc 0x%0h expected no entry", bus.deq_data.pc);
         end else begin
            mon_exp = exp_q.pop_front();
            if (bus.deq_data.pc !== mon_exp ||
                bus.deq_data.predicted_pc !== pred_of(mon_exp) ||
                bus.deq_data.branch_pred !== mon_exp[2] ||
                bus.deq_data.rvfi.monitor_inst !== inst_of(mon_exp) ||
                bus.deq_data.rvfi.monitor_valid !== 1'b1) begin
               bad++;
               $display("FAIL deq_entry: got pc 0x%0h pred 0x%0h inst 0x%0h expected pc 0x%0h pred 0x%0h inst 0x%0h",
                        bus.deq_data.pc, bus.deq_data.predicted_pc,
                        bus.deq_data.rvfi.monitor_inst, mon_exp, pred_of(mon_exp),
                        inst_of(mon_exp));
            end
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      bus.enq_valid = 1'b0;
      bus.enq_data  = '0;
      bus.deq_ready = 1'b0;
      bus.flush     = 1'b0;

      // Reset state, checked before any clock edge
      #1 rst = 1'b1;
      #2;
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
      chk("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
      chk("rst_overflow", 64'(bus.overflow_err), 64'd0);
      chk("rst_bubble_inst", 64'(bus.deq_data.rvfi.monitor_inst), 64'h13);
      chk("rst_bubble_mvalid", 64'(bus.deq_data.rvfi.monitor_valid), 64'd0);
      chk("rst_bubble_bpred", 64'(bus.deq_data.branch_pred), 64'd0);
      tick();
      tick();
      rst = 1'b0;

      // Fill then drain
      for (int i = 0; i < 4; i++) begin
         drive_enq(32'h1000 + 32'(i * 4), 1'b1);
         tick();
         if (i == 0) chk("first_enq_after_rst", 64'(bus.count), 64'd1);
      end
      bus.enq_valid = 1'b0;
      chk("fill_count", 64'(bus.count), 64'd4);
      chk("fill_enq_ready", 64'(bus.enq_ready), 64'd0);
      chk("fill_deq_valid", 64'(bus.deq_valid), 64'd1);
      bus.deq_ready = 1'b1;
      repeat (4) tick();
      chk("drain_deq_valid", 64'(bus.deq_valid), 64'd0);
      chk("drain_bubble_inst", 64'(bus.deq_data.rvfi.monitor_inst), 64'h13);
      chk("drain_count", 64'(bus.count), 64'd0);

      // Streaming with pointer wrap
      for (int i = 0; i < 10; i++) begin
         drive_enq(32'(i * 4), 1'b1);
         tick();
         chk("stream_count", 64'(bus.count), 64'd1);
         chk("stream_head_pc", 64'(bus.deq_data.pc), 64'(i * 4));
      end
      bus.enq_valid = 1'b0;
      tick();
      chk("stream_end_count", 64'(bus.count), 64'd0);

      // Flush with simultaneous enqueue and dequeue at count=3
      bus.deq_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_enq(32'h3000 + 32'(i * 4), 1'b1);
         tick();
      end
      bus.enq_valid = 1'b0;
      chk("preflush_count", 64'(bus.count), 64'd3);
      drive_enq(32'h300C, 1'b0);
      bus.deq_ready = 1'b1;
      bus.flush     = 1'b1;
      exp_q.delete();
      tick();
      bus.flush     = 1'b0;
      bus.enq_valid = 1'b0;
      bus.deq_ready = 1'b0;
      chk("flush_count", 64'(bus.count), 64'd0);
      chk("flush_deq_valid", 64'(bus.deq_valid), 64'd0);
      drive_enq(32'h3100, 1'b1);
      tick();
      bus.enq_valid = 1'b0;
      bus.deq_ready = 1'b1;
      tick();
      tick();
      chk("postflush_count", 64'(bus.count), 64'd0);

      // Overflow
      bus.deq_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_enq(32'h4000 + 32'(i * 4), 1'b1);
         tick();
      end
      chk("prefull_overflow", 64'(bus.overflow_err), 64'd0);
      drive_enq(32'h4010, 1'b0);
      tick();
      bus.enq_valid = 1'b0;
      chk("ovf_set", 64'(bus.overflow_err), 64'd1);
      chk("ovf_count", 64'(bus.count), 64'd4);
      bus.deq_ready = 1'b1;
      repeat (5) tick();
      bus.deq_ready = 1'b0;
      chk("ovf_drain_count", 64'(bus.count), 64'd0);
      chk("ovf_sticky", 64'(bus.overflow_err), 64'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("ovf_after_flush", 64'(bus.overflow_err), 64'd1);

      // Asynchronous reset mid-cycle at count=2
      drive_enq(32'h5000, 1'b1);
      tick();
      drive_enq(32'h5004, 1'b1);
      tick();
      bus.enq_valid = 1'b0;
      chk("prerst_count", 64'(bus.count), 64'd2);
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      chk("arst_count", 64'(bus.count), 64'd0);
      chk("arst_deq_valid", 64'(bus.deq_valid), 64'd0);
      chk("arst_overflow", 64'(bus.overflow_err), 64'd0);
      chk("arst_enq_ready", 64'(bus.enq_ready), 64'd1);
      #2 rst = 1'b0;
      drive_enq(32'h2000, 1'b1);
      bus.deq_ready = 1'b1;
      tick();
      bus.enq_valid = 1'b0;
      chk("arst_first_valid", 64'(bus.deq_valid), 64'd1);
      chk("arst_first_pc", 64'(bus.deq_data.pc), 64'h2000);
      tick();
      chk("arst_end_count", 64'(bus.count), 64'd0);

      // Head hold under backpressure with continued enqueue attempts
      bus.deq_ready = 1'b0;
      drive_enq(32'h6000, 1'b1);
      tick();
      drive_enq(32'h6004, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive_enq(32'h6008 + 32'(i * 4), i < 2);
         tick();
         chk("hold_head_pc", 64'(bus.deq_data.pc), 64'h6000);
      end
      bus.enq_valid = 1'b0;
      chk("hold_count", 64'(bus.count), 64'd4);
      chk("hold_enq_ready", 64'(bus.enq_ready), 64'd0);
      bus.deq_ready = 1'b1;
      repeat (5) tick();
      bus.deq_ready = 1'b0;
      chk("hold_end_count", 64'(bus.count), 64'd0);

      chk("leftover_expected", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_id_fifo.md
IF_ID_FIFO -- requirements
Module: if_id_fifo

Interface
REQ-001 Parameter: DEPTH, default 4, number of instruction entries; power of two, >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 enq_valid  input  1  fetch presents a valid if_id_reg_t this cycle (fetch drives it as the inverse of istall).
REQ-005 enq_data  input  if_id_reg_t  fetched entry: pc, branch_pred, predicted_pc, rvfi fields.
REQ-006 enq_ready  output  1  FIFO can accept an entry this cycle.
REQ-007 deq_valid  output  1  head entry is valid for decode.
REQ-008 deq_data  output  if_id_reg_t  head entry.
REQ-009 deq_ready  input  1  decode consumes the head this cycle (decode drives it as the inverse of dstall).
REQ-010 flush  input  1  mispredict or hardware-scheduler swap; discards all entries.
REQ-011 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-012 overflow_err  output  1  sticky error: an enqueue was attempted while full.

Function
REQ-013 Storage: circular buffer of DEPTH entries; read and write pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-014 enq_ready = (count != DEPTH).
  - Purely a function of registered count.
  - No same-cycle pass-through when full.
REQ-015 deq_valid = (count != 0).
REQ-016 Enqueue fires when enq_valid & enq_ready & !flush.
  - Writes enq_data at the write pointer.
  - Write pointer advances by 1, modulo DEPTH.
REQ-017 Dequeue fires when deq_valid & deq_ready & !flush.
  - Read pointer advances by 1, modulo DEPTH.
REQ-018 Latency:
  - An entry enqueued at edge N is visible on deq_data with deq_valid=1 after edge N.
  - This requires all older entries to have drained.
  - There is no combinational enq-to-deq bypass.
REQ-019 Simultaneous enqueue and dequeue in the same cycle:
  - Both fire.
  - count is unchanged.
  - Entry order is preserved.
REQ-020 count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never goes below 0.
REQ-021 Flush has priority over all other operations.
  - Next cycle: count=0 and both pointers=0.
  - Any same-cycle enqueue or dequeue is discarded.
  - Stored contents need not be cleared.
REQ-022 Dequeued order SHALL equal enqueue order: FIFO semantics, no reordering or duplication.
REQ-023 When deq_valid=0, deq_data SHALL present a bubble:
  - rvfi.monitor_valid=0
  - rvfi.monitor_inst=32'h00000013
  - branch_pred=0
  - all other fields pass the head slot unchanged.
REQ-024 When deq_valid=1, deq_data SHALL equal the stored head entry, bit-exact.
REQ-025 Head stability: while deq_valid=1 and deq_ready=0 with no flush, deq_data SHALL hold constant.
REQ-026 overflow_err behaviour:
  - Sets on any cycle with enq_valid=1 & enq_ready=0 & flush=0; that entry is dropped.
  - Once set, it is cleared only by rst.
  - flush does not clear it.
REQ-027 Storage array uses no reset; only pointers, count and overflow_err are reset.

Reset
REQ-028 While rst=1, regardless of clk:
  - count=0, pointers=0, overflow_err=0.
  - deq_valid=0, enq_ready=1.
  - deq_data is the bubble of REQ-023.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-030 First enqueue SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-031 Fill/drain, DEPTH=4, deq_ready=0, enqueue pc 0x1000, 0x1004, 0x1008, 0x100C:
  - count reaches 4 and enq_ready=0.
  - Then deq_ready=1: pc emerges in order 0x1000..0x100C.
  - Then deq_valid=0 and deq_data.rvfi.monitor_inst=0x13.
REQ-032 Wrap-around: stream 10 entries with enq_valid=deq_ready=1 continuously:
  - count stays at 1 after the first edge.
  - Outputs pc 0x0..0x24 in order, one cycle behind input.
  - Pointers wrap twice.
REQ-033 Flush with simultaneous enqueue and dequeue at count=3: next cycle count=0, deq_valid=0, and the flushed-cycle enqueue does not appear later.
REQ-034 Overflow: at count=4 assert enq_valid=1 for one cycle:
  - overflow_err=1, count stays 4, dropped entry never dequeues.
  - overflow_err remains 1 after a flush.
  - overflow_err returns to 0 only after rst.
REQ-035 Async reset: pulse rst between clock edges at count=2 -> count=0 and deq_valid=0 before the next edge.
  - Then enqueue pc 0x2000 on the first edge after release -> deq_data.pc=0x2000 next cycle.
REQ-036 Head hold: at count=2, deq_ready=0 for 5 cycles with enq_valid=1 -> deq_data constant, count saturates at 4, enq_ready=0.
